// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// iteration count and FSM state encodings.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITERS = DEF_WIDTH;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One guard bit above the remainder keeps the borrow sign unambiguous.
  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted + ~{2'b00, divisor} + (WIDTH+2)'(1);
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncate toward zero).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] final_q;
  logic             done_exc;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dq[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign quotient = {dq[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic neg;
  logic ovf;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] q, input logic n);
    logic signed [WIDTH-1:0] qs;
    qs = q;
    return n ? -qs : qs;
  endfunction

  assign op_a     = magnitude(data_operandA);
  assign op_b     = magnitude(data_operandB);
  assign final_q  = apply_sign(quotient, neg);
  assign done_exc = ovf;

  always_ff @(posedge clock) begin
    if (ctrl_DIV) begin
      neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      ovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
    end
  end
`else
  assign op_a     = data_operandA;
  assign op_b     = data_operandB;
  assign final_q  = quotient;
  assign done_exc = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (divisor == '0) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              state          <= ST_IDLE;
            end else if (cnt == LAST) begin
              data_result    <= final_q;
              data_exception <= done_exc;
              data_resultRDY <= 1'b1;
              state          <= ST_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath registers carry no reset; the FSM decides when they matter.
  always_ff @(posedge clock) begin
    if (ctrl_DIV) begin
      dq      <= op_a;
      divisor <= op_b;
      rem     <= '0;
    end else if (state == ST_RUN) begin
      dq  <= quotient;
      rem <= rem_next;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] opa      = '0;
  logic [W-1:0] opb      = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;

  seq_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic e);
    if (y == '0) begin
      q = '0;
      e = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        e = 1'b1;
      end else begin
        q = $signed(x) / $signed(y);
        e = 1'b0;
      end
`else
      q = x / y;
      e = 1'b0;
`endif
    end
  endfunction

  // Model: a start schedules its answer WIDTH edges later (1 edge for /0);
  // a new start or reset replaces/cancels anything pending.
  logic [W-1:0] exp_res = '0;
  logic         exp_exc = 1'b0;
  logic         exp_rdy = 1'b0;
  logic [W-1:0] p_res;
  logic         p_exc;
  bit           pend    = 1'b0;
  int           left    = 0;
  bit           chk_en  = 1'b0;

  always @(posedge clock) begin
    exp_rdy = 1'b0;
    if (reset) begin
      pend    = 1'b0;
      exp_res = '0;
      exp_exc = 1'b0;
      chk_en  = 1'b1;
    end else if (ctrl_DIV) begin
      ref_div(opa, opb, p_res, p_exc);
      pend = 1'b1;
      left = (opb == '0) ? 1 : W;
    end else if (pend) begin
      left--;
      if (left == 0) begin
        exp_rdy = 1'b1;
        exp_res = p_res;
        exp_exc = p_exc;
        pend    = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("resultRDY", W'(data_resultRDY), W'(exp_rdy));
      chk("result", data_result, exp_res);
      chk("exception", W'(data_exception), W'(exp_exc));
    end
  end

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    ctrl_DIV = 1'b1;
    opa      = x;
    opb      = y;
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] lit_res, input logic lit_exc,
                        input int lit_lat, input string name);
    int lat;
    bit got;
    start(x, y);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (data_resultRDY === 1'b1) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no resultRDY within %0d cycles", name, lat);
    end else begin
      chk({name, "_lat"}, W'(lat), W'(lit_lat));
      chk({name, "_res"}, data_result, lit_res);
      chk({name, "_exc"}, W'(data_exception), W'(lit_exc));
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return W'($urandom_range(1, 20));
      2:       return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_res", data_result, '0);
    chk("reset_exc", W'(data_exception), '0);
    chk("reset_rdy", W'(data_resultRDY), '0);

    run_op(100, 7, 14, 1'b0, 32, "div_100_7");
    run_op(5, 0, 0, 1'b1, 1, "div_by_zero");
    run_op(0, 5, 0, 1'b0, 32, "zero_dividend");
`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 1'b0, 32, "neg100_7");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32, "min_by_m1");
    run_op(100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 32, "100_neg7");
`else
    run_op(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 32, "max_by_1");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32, "big_by_max");
`endif

    // Abort: re-pulse at the tenth edge after the first start.
    start(100, 7);
    repeat (8) @(negedge clock);
    run_op(9, 3, 3, 1'b0, 32, "abort_restart");

    // Reset landing on the fifteenth edge of an operation.
    start(100, 7);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_res", data_result, '0);
    chk("midreset_exc", W'(data_exception), '0);
    chk("midreset_rdy", W'(data_resultRDY), '0);
    repeat (40) @(negedge clock);
    run_op(20, 4, 5, 1'b0, 32, "after_reset");

    // Random starts, restarts, aborts and occasional resets.
    repeat (8000) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      reset    = 1'b0;
      if ($urandom_range(0, 99) < 3) begin
        ctrl_DIV = 1'b1;
        opa      = rnd_opnd();
        opb      = rnd_opnd();
      end else if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
      end
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
    reset    = 1'b0;
    repeat (40) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide ports (one clock; reset is synchronous and active-high):
  clock  input  1  sole clock, rising edge
  reset  input  1  synchronous, active-high reset
  ctrl_DIV  input  1  start pulse; operands sampled on the same edge
  data_operandA  input  WIDTH  dividend
  data_operandB  input  WIDTH  divisor
  data_result  output  WIDTH  quotient
  data_exception  output  1  divide-by-zero / overflow flag
  data_resultRDY  output  1  one-cycle result-valid pulse

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-004 Edge E0, where ctrl_DIV=1 is sampled in any state, SHALL capture operands, clear remainder, set counter=0, and enter RUN.
REQ-005 RUN SHALL perform one restoring shift-subtract step per edge: shift remainder left, bring in the next dividend MSB, subtract the divisor (add inverted divisor, carry-in 1), keep the difference if non-negative, and set the quotient bit.
REQ-006 After WIDTH steps (edges E1..E32) SHALL register data_result, enter DONE, and drive data_resultRDY=1 for exactly the cycle after E32; DONE→IDLE on the next edge.
REQ-007 Divisor=0 SHALL skip iteration: at E1 data_result=0, data_exception=1, data_resultRDY=1, then IDLE.
REQ-008 data_result and data_exception SHALL hold their values until the next completion or reset; data_resultRDY SHALL be 0 in all other cycles.
REQ-009 ctrl_DIV=1 during RUN or DONE SHALL abort the current operation without a resultRDY pulse and restart per REQ-004.
REQ-010 Dividend=0 with non-zero divisor SHALL still take full latency and return 0, exception 0.
REQ-011 Remainder SHALL be internal only, WIDTH+1 bits wide to hold the subtraction borrow.

Reset
REQ-012 reset=1 at an edge SHALL force IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, regardless of state.
REQ-013 reset SHALL take priority over a coincident ctrl_DIV; any in-flight operation SHALL be discarded without a pulse.

Configuration
REQ-014 With DIV_SIGNED_EN defined: operands are two's complement, magnitudes are divided, quotient negated when sign bits differ, and truncation is toward zero.
REQ-015 With DIV_SIGNED_EN defined: most-negative / -1 SHALL return 0x80000000 with data_exception=1 at normal latency.
REQ-016 Without DIV_SIGNED_EN: operands are unsigned, no sign logic is synthesized, and exception occurs only on divide-by-zero.
REQ-017 Latency SHALL be identical in both configurations; sign fix-up is folded into the E32 register update.

Structure
REQ-018 Shared package SHALL hold WIDTH default, the FSM state enum, and the iteration-count constant (WIDTH).
REQ-019 SHALL instantiate one sub-module div_step: combinational single shift-subtract step with remainder/divisor in and next remainder plus quotient bit out.
REQ-020 Top level SHALL contain only the FSM, counter, and operand/result registers.

Verification
REQ-021 A=100, B=7, ctrl_DIV pulse at E0 -> resultRDY=1 only after E32, result=14, exception=0.
REQ-022 A=5, B=0 -> resultRDY after E1, result=0, exception=1.
REQ-023 DIV_SIGNED_EN: A=0xFFFFFF9C (-100), B=7 -> result=0xFFFFFFF2; A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1. Unsigned build: A=0xFFFFFFFF, B=1 -> 0xFFFFFFFF.
REQ-024 Start 100/7, re-pulse ctrl_DIV at E10 with 9/3 -> no pulse for the first op; result=3, 32 edges after the re-pulse.
REQ-025 reset at E15 mid-operation -> all outputs 0, no resultRDY; a later start of 20/4 returns 5.
